// File: rtl/l3_memory_request_unit_pkg.sv
// Shared configuration for the L3 main-memory request path.
// Carries the cache-line geometry, the main-memory interface widths and the
// request-sequencing state type used by l3_memory_request_unit and
// mem_beat_sequencer. The optional watchdog is enabled with MEM_TIMEOUT_EN.
package l3_memory_request_unit_pkg;

    // Main-memory interface widths
    localparam int MAIN_MEMORY_ADDRESS_WIDTH = 16;
    localparam int MAIN_MEMORY_DATA_WIDTH    = 32;

    // L3-side word address width
    localparam int ADDRESS_WIDTH = 16;

    // Default line geometry: main-memory words per cache line
    localparam int CACHE_WORDS_PER_LINE = 4;

    // Request sequencing states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WB_BEAT = 3'd1,
        WB_GAP  = 3'd2,
        RD_BEAT = 3'd3,
        RD_GAP  = 3'd4,
        DONE    = 3'd5
    } mem_req_state_t;

endpackage

// File: rtl/l3_memory_request_unit_beat_sequencer.sv
// mem_beat_sequencer: walks the writeback and fill phases one word beat at a
// time. It owns the beat counter, the one-cycle gap between beats, beat
// completion detection and, when MEM_TIMEOUT_EN is defined, the per-beat
// watchdog that aborts a stuck transfer.
module mem_beat_sequencer
    import l3_memory_request_unit_pkg::*;
#(
    parameter int WORDS_PER_LINE = CACHE_WORDS_PER_LINE
`ifdef MEM_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start_wb,
    input  logic                              start_fill,
    input  logic                              fill_pending,
    input  logic                              mem_ready,
    output mem_req_state_t                    state,
    output logic [$clog2(WORDS_PER_LINE)-1:0] beat_idx,
    output logic                              beat_fire,
    output logic                              timeout
);

    localparam int BEAT_IDX_W = $clog2(WORDS_PER_LINE);
    localparam logic [BEAT_IDX_W-1:0] LAST_IDX = BEAT_IDX_W'(WORDS_PER_LINE - 1);

    mem_req_state_t        state_q;
    mem_req_state_t        state_d;
    logic [BEAT_IDX_W-1:0] idx_q;
    logic                  in_beat;
    logic                  last_beat;
    logic                  abort;

    assign in_beat   = (state_q == WB_BEAT) || (state_q == RD_BEAT);
    assign beat_fire = in_beat && mem_ready;
    assign last_beat = (idx_q == LAST_IDX);
    assign state     = state_q;
    assign beat_idx  = idx_q;

`ifdef MEM_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_q;
    logic            timeout_q;

    assign abort   = in_beat && !mem_ready && (wd_q == WD_LIMIT);
    assign timeout = timeout_q;

    // Watchdog: count stalled request cycles, restart on each completed beat, latch the error
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (in_beat && !mem_ready && !abort) begin
                wd_q <= wd_q + 1'b1;
            end else begin
                wd_q <= '0;
            end
            if (abort) begin
                timeout_q <= 1'b1;
            end
        end
    end
`else
    assign abort   = 1'b0;
    assign timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Beat counter: advances in each gap and wraps back to 0 after the last word
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q <= '0;
        end else if (abort) begin
            idx_q <= '0;
        end else if ((state_q == WB_GAP) || (state_q == RD_GAP)) begin
            idx_q <= idx_q + 1'b1;
        end
    end

    // Next state: writeback beats first, then fill beats, a gap after every beat
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_wb) begin
                    state_d = WB_BEAT;
                end else if (start_fill) begin
                    state_d = RD_BEAT;
                end
            end
            WB_BEAT: begin
                if (abort) begin
                    state_d = DONE;
                end else if (mem_ready) begin
                    state_d = WB_GAP;
                end
            end
            WB_GAP: begin
                if (!last_beat) begin
                    state_d = WB_BEAT;
                end else if (fill_pending) begin
                    state_d = RD_BEAT;
                end else begin
                    state_d = DONE;
                end
            end
            RD_BEAT: begin
                if (abort) begin
                    state_d = DONE;
                end else if (mem_ready) begin
                    state_d = RD_GAP;
                end
            end
            RD_GAP: begin
                state_d = last_beat ? DONE : RD_BEAT;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/l3_memory_request_unit.sv
// l3_memory_request_unit: initiator between the L3 cache controller and the
// main-memory controller. Captures one victim writeback and/or one line fill,
// issues them as single-word beats (writeback always first) and assembles the
// fill line for L3. Defining MEM_TIMEOUT_EN adds a per-beat watchdog that
// raises a sticky mem_timeout and aborts the stuck transfer.
module l3_memory_request_unit
    import l3_memory_request_unit_pkg::*;
#(
    parameter int WORDS_PER_LINE = CACHE_WORDS_PER_LINE
`ifdef MEM_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                                             clk,
    input  logic                                             reset,
    input  logic                                             l3_fill_valid,
    input  logic [ADDRESS_WIDTH-1:0]                         l3_fill_address,
    input  logic                                             l3_wb_valid,
    input  logic [ADDRESS_WIDTH-1:0]                         l3_wb_address,
    input  logic [WORDS_PER_LINE*MAIN_MEMORY_DATA_WIDTH-1:0] l3_wb_data,
    output logic                                             l3_req_ready,
    output logic                                             l3_wb_done,
    output logic                                             l3_fill_done,
    output logic [WORDS_PER_LINE*MAIN_MEMORY_DATA_WIDTH-1:0] l3_fill_data,
    output logic                                             main_memory_read_request,
    output logic                                             main_memory_write_request,
    output logic [MAIN_MEMORY_ADDRESS_WIDTH-1:0]             main_memory_address,
    output logic [MAIN_MEMORY_DATA_WIDTH-1:0]                main_memory_write_data,
    input  logic [MAIN_MEMORY_DATA_WIDTH-1:0]                main_memory_read_data,
    input  logic                                             main_memory_ready,
    output logic                                             mem_timeout
);

    localparam int BEAT_IDX_W = $clog2(WORDS_PER_LINE);
    localparam logic [ADDRESS_WIDTH-1:0] LINE_OFFSET_MASK = ADDRESS_WIDTH'(WORDS_PER_LINE - 1);

    typedef logic [WORDS_PER_LINE-1:0][MAIN_MEMORY_DATA_WIDTH-1:0] line_t;

    mem_req_state_t                       state;
    logic [BEAT_IDX_W-1:0]                beat_idx;
    logic                                 beat_fire;
    logic                                 accept;
    logic                                 has_wb;
    logic                                 has_fill;
    logic [MAIN_MEMORY_ADDRESS_WIDTH-1:0] wb_base;
    logic [MAIN_MEMORY_ADDRESS_WIDTH-1:0] fill_base;
    logic [MAIN_MEMORY_ADDRESS_WIDTH-1:0] wb_base_in;
    logic [MAIN_MEMORY_ADDRESS_WIDTH-1:0] fill_base_in;
    line_t                                wb_words;
    line_t                                fill_words;

    assign accept       = (state == IDLE) && (l3_wb_valid || l3_fill_valid);
    assign wb_base_in   = MAIN_MEMORY_ADDRESS_WIDTH'(l3_wb_address & ~LINE_OFFSET_MASK);
    assign fill_base_in = MAIN_MEMORY_ADDRESS_WIDTH'(l3_fill_address & ~LINE_OFFSET_MASK);

    assign l3_req_ready              = (state == IDLE);
    assign l3_wb_done                = (state == DONE) && has_wb;
    assign l3_fill_done              = (state == DONE) && has_fill;
    assign l3_fill_data              = fill_words;
    assign main_memory_write_request = (state == WB_BEAT);
    assign main_memory_read_request  = (state == RD_BEAT);

    mem_beat_sequencer #(
        .WORDS_PER_LINE (WORDS_PER_LINE)
`ifdef MEM_TIMEOUT_EN
        , .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
`endif
    ) u_sequencer (
        .clk          (clk),
        .reset        (reset),
        .start_wb     (l3_wb_valid),
        .start_fill   (l3_fill_valid),
        .fill_pending (has_fill),
        .mem_ready    (main_memory_ready),
        .state        (state),
        .beat_idx     (beat_idx),
        .beat_fire    (beat_fire),
        .timeout      (mem_timeout)
    );

    // Capture the request on accept and pack returned read words into the fill line
    always_ff @(posedge clk) begin
        if (reset) begin
            has_wb     <= 1'b0;
            has_fill   <= 1'b0;
            wb_base    <= '0;
            fill_base  <= '0;
            wb_words   <= '0;
            fill_words <= '0;
        end else if (accept) begin
            has_wb    <= l3_wb_valid;
            has_fill  <= l3_fill_valid;
            wb_base   <= wb_base_in;
            fill_base <= fill_base_in;
            wb_words  <= l3_wb_data;
            if (l3_fill_valid) begin
                fill_words <= '0;
            end
        end else if (beat_fire && (state == RD_BEAT)) begin
            fill_words[beat_idx] <= main_memory_read_data;
        end
    end

    // Beat address and write data, driven only while a request is up
    always_comb begin
        main_memory_address    = '0;
        main_memory_write_data = '0;
        if (state == WB_BEAT) begin
            main_memory_address    = wb_base + MAIN_MEMORY_ADDRESS_WIDTH'(beat_idx);
            main_memory_write_data = wb_words[beat_idx];
        end else if (state == RD_BEAT) begin
            main_memory_address = fill_base + MAIN_MEMORY_ADDRESS_WIDTH'(beat_idx);
        end
    end

endmodule

// File: tb/tb_l3_memory_request_unit.sv
// Testbench for l3_memory_request_unit. Expected beats, fill lines and done
// timing come from a transaction-level model held in this file. Build with
// MEM_TIMEOUT_EN defined to also exercise the watchdog (TIMEOUT_CYCLES=16).
module tb_l3_memory_request_unit;
    import l3_memory_request_unit_pkg::*;

    localparam int W            = CACHE_WORDS_PER_LINE;
    localparam int DW           = MAIN_MEMORY_DATA_WIDTH;
    localparam int AW           = ADDRESS_WIDTH;
    localparam int MAW          = MAIN_MEMORY_ADDRESS_WIDTH;
    localparam int LW           = W * DW;
    localparam int CYCLE_BUDGET = 400;
    localparam int TB_TIMEOUT   = 16;

    typedef logic [W-1:0][DW-1:0] line_t;
    typedef struct {
        bit             is_write;
        logic [MAW-1:0] addr;
        logic [DW-1:0]  data;
    } beat_t;

    logic           clk = 1'b0;
    logic           reset;
    logic           l3_fill_valid;
    logic [AW-1:0]  l3_fill_address;
    logic           l3_wb_valid;
    logic [AW-1:0]  l3_wb_address;
    logic [LW-1:0]  l3_wb_data;
    logic           l3_req_ready;
    logic           l3_wb_done;
    logic           l3_fill_done;
    logic [LW-1:0]  l3_fill_data;
    logic           main_memory_read_request;
    logic           main_memory_write_request;
    logic [MAW-1:0] main_memory_address;
    logic [DW-1:0]  main_memory_write_data;
    logic [DW-1:0]  main_memory_read_data;
    logic           main_memory_ready;
    logic           mem_timeout;

    int    checks = 0;
    int    fails  = 0;
    beat_t exp_q[$];
    line_t exp_fill_line;
    bit    seq_read_data;

    l3_memory_request_unit #(
        .WORDS_PER_LINE (W)
`ifdef MEM_TIMEOUT_EN
        , .TIMEOUT_CYCLES (TB_TIMEOUT)
`endif
    ) dut (
        .clk                       (clk),
        .reset                     (reset),
        .l3_fill_valid             (l3_fill_valid),
        .l3_fill_address           (l3_fill_address),
        .l3_wb_valid               (l3_wb_valid),
        .l3_wb_address             (l3_wb_address),
        .l3_wb_data                (l3_wb_data),
        .l3_req_ready              (l3_req_ready),
        .l3_wb_done                (l3_wb_done),
        .l3_fill_done              (l3_fill_done),
        .l3_fill_data              (l3_fill_data),
        .main_memory_read_request  (main_memory_read_request),
        .main_memory_write_request (main_memory_write_request),
        .main_memory_address       (main_memory_address),
        .main_memory_write_data    (main_memory_write_data),
        .main_memory_read_data     (main_memory_read_data),
        .main_memory_ready         (main_memory_ready),
        .mem_timeout               (mem_timeout)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Count one comparison and report it when it does not hold
    task automatic checkOutput(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Line base in main-memory word space: drop the in-line word offset
    function automatic logic [MAW-1:0] lineBase(input logic [AW-1:0] a);
        int unsigned v;
        v = a;
        return MAW'(v - (v % W));
    endfunction

    function automatic line_t randomLine();
        line_t l;
        for (int i = 0; i < W; i++) begin
            l[i] = $urandom;
        end
        return l;
    endfunction

    // Run one L3 request to completion (or to a reset abort) and check every beat.
    // ready_mode: 0 zero-wait, 1 one-cycle wait, 2 random, 3 long stall on beat 2, 4 never ready
    task automatic applyStimulus(input bit do_wb, input bit do_fill,
                                 input logic [AW-1:0] wb_addr, input logic [AW-1:0] fill_addr,
                                 input line_t wb_words, input int ready_mode, input int reset_at_read);
        beat_t b;
        int    cycle;
        int    req_cycles;
        int    beat_no;
        int    reads_done;
        bit    done_seen;
        bit    aborted;
        bit    prev_fire;
        bit    fire;
        bit    rd;
        bit    wr;

        exp_q.delete();
        for (int i = 0; i < W; i++) begin
            if (do_wb) begin
                b.is_write = 1'b1;
                b.addr     = lineBase(wb_addr) + MAW'(i);
                b.data     = wb_words[i];
                exp_q.push_back(b);
            end
        end
        for (int i = 0; i < W; i++) begin
            if (do_fill) begin
                b.is_write = 1'b0;
                b.addr     = lineBase(fill_addr) + MAW'(i);
                b.data     = '0;
                exp_q.push_back(b);
            end
        end
        if (do_fill) begin
            exp_fill_line = '0;
        end

        checkOutput("ready_before_accept", l3_req_ready, 1'b1);
        l3_wb_valid     = do_wb;
        l3_fill_valid   = do_fill;
        l3_wb_address   = wb_addr;
        l3_fill_address = fill_addr;
        l3_wb_data      = wb_words;
        @(negedge clk);
        l3_wb_valid     = 1'b0;
        l3_fill_valid   = 1'b0;
        l3_wb_address   = AW'($urandom);
        l3_fill_address = AW'($urandom);
        l3_wb_data      = randomLine();

        cycle      = 1;
        req_cycles = 0;
        beat_no    = 0;
        reads_done = 0;
        done_seen  = 1'b0;
        aborted    = 1'b0;
        prev_fire  = 1'b0;
        while (!done_seen && !aborted && cycle <= CYCLE_BUDGET) begin
            rd = main_memory_read_request;
            wr = main_memory_write_request;
            checkOutput("req_exclusive", rd & wr, 1'b0);
            checkOutput("ready_low_busy", l3_req_ready, 1'b0);
            if (prev_fire) begin
                checkOutput("gap_after_beat", rd | wr, 1'b0);
            end
            if (rd || wr) begin
                req_cycles++;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_beat", 1'b1, 1'b0);
                end else begin
                    checkOutput("beat_is_write", wr, exp_q[0].is_write);
                    checkOutput("beat_address", main_memory_address, exp_q[0].addr);
                    if (wr) begin
                        checkOutput("beat_write_data", main_memory_write_data, exp_q[0].data);
                    end
                    if (rd && reads_done == reset_at_read) begin
                        aborted = 1'b1;
                    end
                end
            end
            if (l3_wb_done || l3_fill_done) begin
                done_seen = 1'b1;
                checkOutput("wb_done", l3_wb_done, do_wb);
                checkOutput("fill_done", l3_fill_done, do_fill);
                checkOutput("fill_data", l3_fill_data, exp_fill_line);
                checkOutput("mem_timeout_at_done", mem_timeout, ready_mode == 4);
                if (ready_mode == 4) begin
                    checkOutput("latency_timeout", cycle, TB_TIMEOUT + 1);
                end else begin
                    checkOutput("beats_outstanding", exp_q.size(), 0);
                end
                if (ready_mode == 0) begin
                    checkOutput("latency_zero_wait", cycle, 2 * W * (int'(do_wb) + int'(do_fill)) + 1);
                end
            end

            fire = 1'b0;
            if (aborted) begin
                reset             = 1'b1;
                main_memory_ready = 1'b0;
            end else begin
                case (ready_mode)
                    0:       main_memory_ready = 1'b1;
                    1:       main_memory_ready = (req_cycles >= 2);
                    2:       main_memory_ready = ($urandom_range(0, 1) == 1) || (req_cycles >= 8);
                    3:       main_memory_ready = (rd || wr) ? (beat_no != 1 || req_cycles >= 6)
                                                            : ($urandom_range(0, 1) == 1);
                    default: main_memory_ready = 1'b0;
                endcase
                main_memory_read_data = seq_read_data ? DW'(32'hA0 + reads_done) : $urandom;
                fire = (rd || wr) && main_memory_ready && !done_seen && (exp_q.size() > 0);
                if (fire) begin
                    if (rd) begin
                        exp_fill_line[reads_done] = main_memory_read_data;
                        reads_done++;
                    end
                    void'(exp_q.pop_front());
                    beat_no++;
                    req_cycles = 0;
                end
            end
            prev_fire = fire;
            @(negedge clk);
            cycle++;
        end

        main_memory_ready = 1'b0;
        if (aborted) begin
            checkOutput("reset_abort_requests", {main_memory_read_request, main_memory_write_request}, 2'b00);
            checkOutput("reset_abort_ready", l3_req_ready, 1'b1);
            checkOutput("reset_abort_no_done", {l3_wb_done, l3_fill_done}, 2'b00);
            checkOutput("reset_abort_fill_cleared", l3_fill_data, '0);
            reset         = 1'b0;
            exp_fill_line = '0;
        end else if (!done_seen) begin
            checkOutput("done_within_budget", 1'b0, 1'b1);
        end else begin
            checkOutput("idle_after_done", l3_req_ready, 1'b1);
            checkOutput("done_is_pulse", {l3_wb_done, l3_fill_done}, 2'b00);
            checkOutput("idle_requests", {main_memory_read_request, main_memory_write_request}, 2'b00);
        end
    endtask

    // Directed scenarios followed by randomized requests
    initial begin
        line_t wl;
        int    sel;
        int    mode;

        reset                 = 1'b1;
        l3_fill_valid         = 1'b0;
        l3_wb_valid           = 1'b0;
        l3_fill_address       = '0;
        l3_wb_address         = '0;
        l3_wb_data            = '0;
        main_memory_read_data = '0;
        main_memory_ready     = 1'b0;
        seq_read_data         = 1'b0;
        exp_fill_line         = '0;

        repeat (2) @(negedge clk);
        checkOutput("reset_req_ready", l3_req_ready, 1'b1);
        checkOutput("reset_requests", {main_memory_read_request, main_memory_write_request}, 2'b00);
        checkOutput("reset_dones", {l3_wb_done, l3_fill_done}, 2'b00);
        checkOutput("reset_address", main_memory_address, '0);
        checkOutput("reset_write_data", main_memory_write_data, '0);
        checkOutput("reset_fill_data", l3_fill_data, '0);
        checkOutput("reset_mem_timeout", mem_timeout, 1'b0);
        reset = 1'b0;

        $display("[TB] stray ready while idle");
        main_memory_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("idle_stray_ready", {main_memory_read_request, main_memory_write_request}, 2'b00);
            checkOutput("idle_stays_ready", l3_req_ready, 1'b1);
        end
        main_memory_ready = 1'b0;

        $display("[TB] fill only, one-cycle memory wait");
        seq_read_data = 1'b1;
        applyStimulus(1'b0, 1'b1, '0, 16'h0102, '0, 1, -1);
        checkOutput("fill_line_a0_a3", l3_fill_data, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
        seq_read_data = 1'b0;

        $display("[TB] writeback only, zero-wait memory");
        wl[0] = 32'h11;
        wl[1] = 32'h12;
        wl[2] = 32'h13;
        wl[3] = 32'h14;
        applyStimulus(1'b1, 1'b0, 16'h0040, '0, wl, 0, -1);
        checkOutput("fill_held_after_wb", l3_fill_data, {32'hA3, 32'hA2, 32'hA1, 32'hA0});

        $display("[TB] writeback and fill together, zero-wait memory");
        applyStimulus(1'b1, 1'b1, 16'h0200, 16'h0300, randomLine(), 0, -1);

        $display("[TB] stalled memory with stray ready pulses");
        applyStimulus(1'b1, 1'b1, 16'h0417, 16'h0523, randomLine(), 3, -1);

        $display("[TB] reset during read beat 2, then a clean fill");
        applyStimulus(1'b0, 1'b1, '0, 16'h0606, '0, 1, 1);
        applyStimulus(1'b0, 1'b1, '0, 16'h0608, '0, 1, -1);

        $display("[TB] randomized requests");
        repeat (20) begin
            sel  = $urandom_range(1, 3);
            mode = $urandom_range(0, 2);
            applyStimulus((sel & 1) != 0, (sel & 2) != 0, AW'($urandom), AW'($urandom),
                          randomLine(), mode, -1);
        end

`ifdef MEM_TIMEOUT_EN
        $display("[TB] watchdog with memory never ready");
        applyStimulus(1'b0, 1'b1, '0, 16'h0700, '0, 4, -1);
        checkOutput("timeout_sticky", mem_timeout, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset         = 1'b0;
        exp_fill_line = '0;
        checkOutput("timeout_cleared_by_reset", mem_timeout, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // Absolute bound on simulation time
    initial begin
        #2000000;
        $display("[TB] FAIL global_time_limit: got no end of test expected end of test");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule

// File: doc/l3_memory_request_unit.md
Name: l3_memory_request_unit

Overview:
Initiator side of the main-memory interface, placed between the shared L3 cache_fsm and main_memory_controller. It accepts one line-fill and/or one dirty-victim writeback from L3. It then sequences them as single-word beats on the main-memory read/write handshake and returns the assembled fill line to L3. Writeback always completes before fill, so memory never returns stale data for a line being evicted and re-fetched.

Parameters:
WORDS_PER_LINE, 4, main-memory words per cache line; power of two, >=2
BEAT_IDX_W, $clog2(WORDS_PER_LINE), beat counter / line-offset width (derived, not overridden)
TIMEOUT_CYCLES, 1024, watchdog limit per beat (used only with MEM_TIMEOUT_EN)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
l3_fill_valid  in  1  L3 requests line fill
l3_fill_address  in  ADDRESS_WIDTH  word address of line to fill; low BEAT_IDX_W bits ignored
l3_wb_valid  in  1  L3 requests victim writeback
l3_wb_address  in  ADDRESS_WIDTH  word address of victim line; low BEAT_IDX_W bits ignored
l3_wb_data  in  WORDS_PER_LINE*MAIN_MEMORY_DATA_WIDTH  victim line, word 0 in LSBs
l3_req_ready  out  1  unit idle, L3 request accepted this cycle if valid
l3_wb_done  out  1  one-cycle pulse: writeback complete
l3_fill_done  out  1  one-cycle pulse: l3_fill_data valid
l3_fill_data  out  WORDS_PER_LINE*MAIN_MEMORY_DATA_WIDTH  filled line, word 0 in LSBs, held until next accept
main_memory_read_request  out  1  read beat request
main_memory_write_request  out  1  write beat request
main_memory_address  out  MAIN_MEMORY_ADDRESS_WIDTH  beat word address
main_memory_write_data  out  MAIN_MEMORY_DATA_WIDTH  write beat data
main_memory_read_data  in  MAIN_MEMORY_DATA_WIDTH  read beat data, valid with main_memory_ready
main_memory_ready  in  1  memory completes current beat
mem_timeout  out  1  sticky watchdog error (MEM_TIMEOUT_EN only; else tied 0)

Behaviour:
- Reset: state IDLE. All outputs 0, except l3_req_ready=1 and l3_fill_data cleared to 0. Beat counter 0.
- Accept: in IDLE, l3_req_ready=1. On an edge with either valid high, capture addresses, with low BEAT_IDX_W bits forced 0 and zero-extended/truncated to MAIN_MEMORY_ADDRESS_WIDTH. Also capture wb data and both valid flags. l3_req_ready drops the next cycle.
- Both valids in the same cycle: WB then RD. Only one valid: that phase only. Both low: stay IDLE.
- States: IDLE -> WB_BEAT (if wb) or RD_BEAT (if fill only).
  - WB_BEAT -> WB_GAP -> WB_BEAT until the last beat, then RD_BEAT (fill pending) or DONE.
  - RD_BEAT -> RD_GAP -> RD_BEAT until the last beat, then DONE.
  - DONE -> IDLE.
- Beat: request held high with stable address/data. The beat completes on an edge where request=1 and main_memory_ready=1, including the first cycle of the request. The GAP state drives request low for exactly one cycle between beats; the counter increments in GAP.
- Beat address = line base + counter (counter wraps to 0 at end of phase). Write data = wb word[counter]. Read data is stored into fill word[counter] on the completing edge.
- main_memory_ready while no request is active is ignored. read_request and write_request are never both high.
- DONE cycle: l3_wb_done=1 if a wb was captured; l3_fill_done=1 if a fill was captured. Both pulse together when both were requested.
- Minimum latency, zero-wait memory: wb-only = 2*WORDS_PER_LINE+1 cycles from accept to done; wb+fill = 4*WORDS_PER_LINE+1.
- Reset mid-operation: the next edge returns to IDLE. Requests drop and no done pulse is issued; the partial fill is discarded.

Optional Feature:
MEM_TIMEOUT_EN
- Defined:
  - A counter runs while any request is high without ready and clears on beat completion.
  - Reaching TIMEOUT_CYCLES sets mem_timeout (sticky until reset), aborts to DONE, and pulses the done outputs of the captured requests. l3_fill_data holds the words received so far.
- Undefined: no counter, mem_timeout tied 0, the unit waits indefinitely.

Decomposition:
- cache_config: WORDS_PER_LINE default, line-width localparam, and a mem_req_state_t enum (IDLE, WB_BEAT, WB_GAP, RD_BEAT, RD_GAP, DONE).
- main_memory_config: existing MAIN_MEMORY_* widths, unchanged.
- One natural sub-module: mem_beat_sequencer, owning the counter, GAP insertion, completion detect and watchdog. The top level owns capture, phase ordering and line packing.

Test Plan:
- Fill only: l3_fill_address=0x0102, memory ready one cycle after each request, read data 0xA0..0xA3 -> addresses 0x0100..0x0103; l3_fill_data={A3,A2,A1,A0}; single l3_fill_done; l3_wb_done stays 0.
- WB only, zero-wait: l3_wb_address=0x0040, data words 0x11..0x14 -> write beats at 0x0040..0x0043 with 0x11..0x14; request low 1 cycle between beats; l3_wb_done 9 cycles after accept.
- Both valid same cycle, wb 0x0200, fill 0x0300 -> all 4 writes precede all 4 reads; both done pulses in the same cycle, 17 cycles after accept.
- Stalled memory: ready delayed 5 cycles on beat 2 -> request/address/data stable throughout; stray ready pulses in IDLE and GAP are ignored.
- Reset asserted during read beat 2 -> next cycle all requests 0, l3_req_ready=1, no done pulse; a new fill then completes normally.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=16, ready never asserted -> mem_timeout=1 after 16 request cycles; done pulse; unit returns to IDLE.
